icache_l1_dm: RTL

- Direct-mapped, read-only L1 instruction cache between the pipeline's instruction-fetch stage and the 2-way L2 instruction cache.
- Serves 32-bit instruction reads from 4-word (128-bit) lines.
- On a miss, requests one full line from L2 using the L2's 28-bit line-address / 128-bit data / ready handshake.
- Hit result is combinational in the same cycle.

---
 rtl/icache_l1_dm_pkg.sv | 20 ++
 rtl/icache_l1_dm_if.sv | 32 +++
 rtl/icache_l1_array.sv | 58 +++++
 rtl/icache_l1_dm.sv | 101 ++++++++++
 4 files changed

// File: rtl/icache_l1_dm_pkg.sv
// Shared widths, state encoding and word-select helper for the L1 instruction cache and its L2 peer.
package icache_l1_dm_pkg;

    localparam int LINE_W      = 128;
    localparam int WORD_W      = 32;
    localparam int LINE_ADDR_W = 28;
    localparam int PROC_ADDR_W = 30;

    typedef enum logic {
        IDLE     = 1'b0,
        READ_MEM = 1'b1
    } state_e;

    // Word w of a line lives at bits [32w+31:32w].
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        w);
        return line[WORD_W*w +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_l1_dm_if.sv
// Fetch-side and L2-side bus of the L1 instruction cache; slave = cache, master = fetch stage + L2.
interface icache_l1_dm_if;
    import icache_l1_dm_pkg::*;

    // Handshakes: fetch holds proc_read/proc_addr stable while proc_stall=1 and takes proc_rdata
    // in any cycle with proc_read=1 and proc_stall=0. The cache holds mem_read/mem_addr stable
    // until L2 returns the line in a cycle with mem_ready=1; mem_ready without mem_read is ignored.
    logic                   proc_read;
    logic                   proc_write;
    logic [PROC_ADDR_W-1:0] proc_addr;
    logic [WORD_W-1:0]      proc_wdata;
    logic                   proc_stall;
    logic [WORD_W-1:0]      proc_rdata;
    logic                   mem_read;
    logic                   mem_write;
    logic [LINE_ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]      mem_rdata;
    logic [LINE_W-1:0]      mem_wdata;
    logic                   mem_ready;
    state_e                 dbg_state;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata, dbg_state
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata, dbg_state
    );

endinterface

// File: rtl/icache_l1_array.sv
// Valid/tag/data storage for the direct-mapped L1 I-cache: combinational read, one synchronous write.
module icache_l1_array
    import icache_l1_dm_pkg::*;
#(
    parameter int NUM_OF_BLOCK = 8,
    parameter int BLOCK_OFFSET = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BLOCK_OFFSET-1:0]             rd_idx,
    output logic                                rd_valid,
    output logic [LINE_ADDR_W-BLOCK_OFFSET-1:0] rd_tag,
    output logic [LINE_W-1:0]                   rd_line,
    input  logic                                we,
    input  logic [BLOCK_OFFSET-1:0]             wr_idx,
    input  logic [LINE_ADDR_W-BLOCK_OFFSET-1:0] wr_tag,
    input  logic [LINE_W-1:0]                   wr_line
);

    localparam int TAG_W = LINE_ADDR_W - BLOCK_OFFSET;

    logic [NUM_OF_BLOCK-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q   [NUM_OF_BLOCK];
    logic [TAG_W-1:0]        tag_d   [NUM_OF_BLOCK];
    logic [LINE_W-1:0]       data_q  [NUM_OF_BLOCK];
    logic [LINE_W-1:0]       data_d  [NUM_OF_BLOCK];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // A refill overwrites whatever occupied the index; instruction lines are never dirty.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_OF_BLOCK; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/icache_l1_dm.sv
// Direct-mapped read-only L1 instruction cache with single-line L2 refill.
// Build option ICACHE_L1_FWD_EN: return the requested word straight from L2 in the fill cycle.
module icache_l1_dm
    import icache_l1_dm_pkg::*;
#(
    parameter int NUM_OF_BLOCK = 8,
    parameter int BLOCK_OFFSET = 3
) (
    input  logic           clk,
    input  logic           proc_reset,
    icache_l1_dm_if.slave  bus
);

    localparam int TAG_W = LINE_ADDR_W - BLOCK_OFFSET;

    state_e                  state_q, state_d;
    logic [BLOCK_OFFSET-1:0] idx;
    logic [TAG_W-1:0]        tag;
    logic [1:0]              wsel;
    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [LINE_W-1:0]       rd_line;
    logic                    hit;
    logic                    fill;
    logic                    stall;
    logic [WORD_W-1:0]       rdata;
    logic                    unused_ok;

    assign idx  = bus.proc_addr[BLOCK_OFFSET+1:2];
    assign tag  = bus.proc_addr[PROC_ADDR_W-1:BLOCK_OFFSET+2];
    assign wsel = bus.proc_addr[1:0];
    assign hit  = rd_valid && (rd_tag == tag);
    assign fill = (state_q == READ_MEM) && bus.mem_ready;

    icache_l1_array #(
        .NUM_OF_BLOCK (NUM_OF_BLOCK),
        .BLOCK_OFFSET (BLOCK_OFFSET)
    ) u_array (
        .clk      (clk),
        .rst      (proc_reset),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (fill),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_line  (bus.mem_rdata)
    );

    // The miss-detect cycle only moves state; mem_read follows the registered state so that an
    // L2 answering in the same cycle cannot form a loop back through the hit compare.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        rdata   = '0;
        case (state_q)
            IDLE: begin
                if (bus.proc_read) begin
                    if (hit) begin
                        rdata = word_sel(rd_line, wsel);
                    end else begin
                        stall   = 1'b1;
                        state_d = READ_MEM;
                    end
                end
            end
            READ_MEM: begin
                stall = bus.proc_read;
                if (bus.mem_ready) begin
                    state_d = IDLE;
`ifdef ICACHE_L1_FWD_EN
                    stall = 1'b0;
                    rdata = word_sel(bus.mem_rdata, wsel);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.proc_stall = stall;
    assign bus.proc_rdata = rdata;
    assign bus.mem_read   = (state_q == READ_MEM);
    assign bus.mem_addr   = (state_q == READ_MEM) ? bus.proc_addr[PROC_ADDR_W-1:2] : '0;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = '0;
    assign bus.dbg_state  = state_q;

    // Write path of the fetch port has no function in a read-only cache.
    assign unused_ok = ^{bus.proc_write, bus.proc_wdata};

endmodule
